// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, baud codes, frame length.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package uart_tx_arbiter_pkg;

    // Arbiter FSM states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_DONE,
        ST_GAP
    } state_e;

    // Baud_set codes understood by uart_byte_tx.
    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;

    // One UART frame: start bit, 8 data bits, stop bit.
    localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte requesters, the arbiter and the external uart_byte_tx.
// Latency: n/a (wires only).
// Backpressure: Req is a level held until Ack; Tx_Send_Go/Tx_Done are single-cycle pulses.
// Ports: Req/Req_Data/Ack/Err/Busy toward requesters; Tx_Data/Tx_Send_Go/Tx_Done/Baud_set toward the UART.
// slave = arbiter side, master = requester + UART side.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   Req;
    logic [8*NUM_REQ-1:0] Req_Data;
    logic [NUM_REQ-1:0]   Ack;
    logic                 Err;
    logic                 Busy;
    logic [7:0]           Tx_Data;
    logic                 Tx_Send_Go;
    logic                 Tx_Done;
    logic [2:0]           Baud_set;

    modport master (
        output Req, Req_Data, Tx_Done,
        input  Ack, Err, Busy, Tx_Data, Tx_Send_Go, Baud_set
    );

    modport slave (
        input  Req, Req_Data, Tx_Done,
        output Ack, Err, Busy, Tx_Data, Tx_Send_Go, Baud_set
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_select.sv
// Round-robin picker: first asserted Req bit searching upward from Last+1, wrapping at NUM_REQ.
// Latency: combinational.
// Backpressure: none; Valid low when no request is pending.
// Ports: Req (request vector), Last (previous winner) -> Valid, Index.
module rr_select #(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] Req,
    input  logic [IW-1:0]      Last,
    output logic               Valid,
    output logic [IW-1:0]      Index
);
    logic [IW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest hit overwrites the rest;
    // offset NUM_REQ lands back on Last itself, which is how a lone requester is re-granted.
    always_comb begin
        Valid = 1'b0;
        Index = '0;
        idx   = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = IW'((int'(Last) + off) % NUM_REQ);
            if (Req[idx]) begin
                Valid = 1'b1;
                Index = idx;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_byte_tx among NUM_REQ byte requesters with round-robin grants and a Tx_Done timeout.
// Latency: Tx_Send_Go in the third cycle of a request seen in IDLE (IDLE, LOAD, SEND); Ack coincident with Tx_Done or timeout.
// Backpressure: requesters hold Req until Ack; one byte in flight, GAP idle cycles after each byte.
// Ports: Clk, Reset (sync, active-high), bus (slave modport: requester and UART handshakes).
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int         NUM_REQ  = 4,
    parameter logic [2:0] BAUD_SET = BAUD_115200,
    parameter int         TIMEOUT  = 65535,
    parameter int         GAP      = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    uart_tx_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    state_e        state_q, state_d;
    logic [IW-1:0] sel_q, sel_d;
    logic [IW-1:0] last_q, last_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;

    logic          rr_valid;
    logic [IW-1:0] rr_index;
    logic [CW-1:0] cnt_inc;
    logic          expired;
    logic          finish;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr_select (
        .Req   (bus.Req),
        .Last  (last_q),
        .Valid (rr_valid),
        .Index (rr_index)
    );

    // cnt_q counts WAIT_DONE cycles already elapsed, so the incremented value reaching
    // TIMEOUT marks the cycle exactly TIMEOUT after the start pulse.
    assign cnt_inc = (cnt_q == TIMEOUT_C) ? cnt_q : cnt_q + 1'b1;
    assign expired = (cnt_inc == TIMEOUT_C);
    // Reset gating keeps a Tx_Done that lands on a reset cycle from acknowledging an aborted byte.
    assign finish  = (state_q == ST_WAIT_DONE) && (bus.Tx_Done || expired) && !Reset;

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        last_d         = last_q;
        tx_data_d      = tx_data_q;
        cnt_d          = cnt_q;
        gap_d          = gap_q;

        bus.Ack        = '0;
        bus.Err        = 1'b0;
        bus.Busy       = (state_q != ST_IDLE);
        bus.Tx_Send_Go = (state_q == ST_SEND) && !Reset;
        bus.Tx_Data    = tx_data_q;
        bus.Baud_set   = BAUD_SET;

        case (state_q)
            ST_IDLE: begin
                if (rr_valid) begin
                    sel_d     = rr_index;
                    tx_data_d = bus.Req_Data[{rr_index, 3'b000} +: 8];
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_SEND;
            ST_SEND: begin
                cnt_d   = '0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                cnt_d = cnt_inc;
                if (finish) begin
                    bus.Ack[sel_q] = 1'b1;
                    // A Tx_Done on the expiry cycle wins: the byte did go out.
                    bus.Err        = !bus.Tx_Done;
                    last_d         = sel_q;
                    gap_d          = '0;
                    state_d        = ST_GAP;
                end
            end
            ST_GAP: begin
                // Always at least one GAP cycle, even with GAP = 0.
                if (int'(gap_q) + 1 >= GAP) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            last_q    <= IW'(NUM_REQ - 1);
            tx_data_q <= 8'h00;
            cnt_q     <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            tx_data_q <= tx_data_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT=200, GAP=2).
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Cycle numbering: the cycle in which Req is first applied in IDLE is cycle 0.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 200;
    localparam int GAP     = 2;

    logic Clk = 1'b0;
    logic Reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] dat [4] = '{8'h55, 8'hAA, 8'hF0, 8'h0F};

    always #5 Clk = ~Clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT),
        .GAP     (GAP)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Called at a drive point; returns on the falling edge of the Tx_Send_Go cycle.
    task automatic wait_go(input int max, output int n, output bit ok);
        n = 0;
        @(negedge Clk);
        while (!bus.Tx_Send_Go && n < max) begin
            step();
            n++;
            @(negedge Clk);
        end
        ok = bus.Tx_Send_Go;
    endtask

    task automatic test_reset();
        step();
        Reset = 1'b1; bus.Req = '0; bus.Tx_Done = 1'b0;
        step();
        step();
        @(negedge Clk);
        n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", bus.Busy); end
        n_checks++; if (bus.Ack !== 4'b0000) begin n_fail++; $display("FAIL rst_ack got %b want 0000", bus.Ack); end
        n_checks++; if (bus.Err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", bus.Err); end
        n_checks++; if (bus.Tx_Send_Go !== 1'b0) begin n_fail++; $display("FAIL rst_go got %b want 0", bus.Tx_Send_Go); end
        n_checks++; if (bus.Tx_Data !== 8'h00) begin n_fail++; $display("FAIL rst_txdata got %h want 00", bus.Tx_Data); end
        n_checks++; if (bus.Baud_set !== 3'd4) begin n_fail++; $display("FAIL rst_baud got %0d want 4", bus.Baud_set); end
        step();
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_single();
        int n; bit ok;
        step();
        bus.Req = 4'b0001; bus.Req_Data = {dat[3], dat[2], dat[1], 8'h5A};
        wait_go(10, n, ok);
        // Go in cycle 2: the third cycle (IDLE, LOAD, SEND).
        n_checks++; if (!ok || n != 2) begin n_fail++; $display("FAIL single_go_latency got %0d ok=%0b want 2", n, ok); end
        n_checks++; if (bus.Tx_Data !== 8'h5A) begin n_fail++; $display("FAIL single_txdata got %h want 5a", bus.Tx_Data); end
        for (int i = 1; i <= 100; i++) begin
            step();
            bus.Tx_Done = (i == 100);
            @(negedge Clk);
            if (i == 50) begin
                n_checks++; if (bus.Ack !== 4'b0000) begin n_fail++; $display("FAIL single_early_ack got %b want 0000", bus.Ack); end
            end
        end
        n_checks++; if (bus.Ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack got %b want 0001", bus.Ack); end
        n_checks++; if (bus.Err !== 1'b0) begin n_fail++; $display("FAIL single_err got %b want 0", bus.Err); end
        step();
        bus.Tx_Done = 1'b0; bus.Req = '0;
        @(negedge Clk);
        n_checks++; if (bus.Ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_pulse got %b want 0000", bus.Ack); end
    endtask

    task automatic test_round_robin();
        int n; bit ok;
        int order [5] = '{0, 1, 2, 3, 0};
        step();
        bus.Req = 4'b1111; bus.Req_Data = {dat[3], dat[2], dat[1], dat[0]};
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                step();
                bus.Tx_Done = 1'b0;
            end
            wait_go(20, n, ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_go_timeout grant %0d", k); end
            if (k > 0) begin
                // Ack cycle, GAP cycles, then IDLE and LOAD before SEND.
                n_checks++; if (n != GAP + 2) begin n_fail++; $display("FAIL rr_gap grant %0d got %0d want %0d", k, n, GAP + 2); end
            end
            n_checks++; if (bus.Tx_Data !== dat[order[k]]) begin n_fail++; $display("FAIL rr_txdata grant %0d got %h want %h", k, bus.Tx_Data, dat[order[k]]); end
            for (int i = 1; i <= 5; i++) begin
                step();
                bus.Tx_Done = (i == 5);
            end
            @(negedge Clk);
            n_checks++; if (bus.Ack !== 4'(1 << order[k])) begin n_fail++; $display("FAIL rr_ack grant %0d got %b want %b", k, bus.Ack, 4'(1 << order[k])); end
            n_checks++; if (bus.Err !== 1'b0) begin n_fail++; $display("FAIL rr_err grant %0d got %b want 0", k, bus.Err); end
        end
        step();
        bus.Tx_Done = 1'b0; bus.Req = '0;
        @(negedge Clk);
    endtask

    task automatic test_timeout();
        int n; bit ok;
        step();
        bus.Req = 4'b0110;
        wait_go(20, n, ok);
        n_checks++; if (!ok || bus.Tx_Data !== dat[1]) begin n_fail++; $display("FAIL to_grant ok=%0b txdata got %h want %h", ok, bus.Tx_Data, dat[1]); end
        n = 0;
        do begin
            step();
            n++;
            @(negedge Clk);
        end while (bus.Ack == 4'b0000 && n < 300);
        n_checks++; if (n != TIMEOUT) begin n_fail++; $display("FAIL to_latency got %0d want %0d", n, TIMEOUT); end
        n_checks++; if (bus.Ack !== 4'b0010) begin n_fail++; $display("FAIL to_ack got %b want 0010", bus.Ack); end
        n_checks++; if (bus.Err !== 1'b1) begin n_fail++; $display("FAIL to_err got %b want 1", bus.Err); end
        step();
        bus.Req = 4'b0100;
        @(negedge Clk);
        n_checks++; if (bus.Err !== 1'b0) begin n_fail++; $display("FAIL to_err_pulse got %b want 0", bus.Err); end
        step();
        wait_go(20, n, ok);
        n_checks++; if (!ok || bus.Tx_Data !== dat[2]) begin n_fail++; $display("FAIL to_next ok=%0b txdata got %h want %h", ok, bus.Tx_Data, dat[2]); end
        for (int i = 1; i <= 3; i++) begin
            step();
            bus.Tx_Done = (i == 3);
        end
        @(negedge Clk);
        n_checks++; if (bus.Ack !== 4'b0100 || bus.Err !== 1'b0) begin n_fail++; $display("FAIL to_next_ack got %b/%b want 0100/0", bus.Ack, bus.Err); end
        step();
        bus.Tx_Done = 1'b0; bus.Req = '0;
        @(negedge Clk);
    endtask

    task automatic test_stray_and_drop();
        int n; bit ok;
        repeat (6) step();
        bus.Tx_Done = 1'b1;
        @(negedge Clk);
        n_checks++; if (bus.Ack !== 4'b0000 || bus.Busy !== 1'b0) begin n_fail++; $display("FAIL stray_ack got ack=%b busy=%b want 0000/0", bus.Ack, bus.Busy); end
        step();
        bus.Tx_Done = 1'b0; bus.Req = 4'b0100; bus.Req_Data[23:16] = 8'h3C;
        // Last winner was 2, so the search wraps 3,0,1 and comes back to 2.
        wait_go(10, n, ok);
        n_checks++; if (!ok || bus.Tx_Data !== 8'h3C) begin n_fail++; $display("FAIL drop_grant ok=%0b txdata got %h want 3c", ok, bus.Tx_Data); end
        step();
        bus.Req = 4'b0000; bus.Req_Data[23:16] = 8'hFF;
        repeat (3) step();
        @(negedge Clk);
        n_checks++; if (bus.Tx_Data !== 8'h3C || bus.Ack !== 4'b0000) begin n_fail++; $display("FAIL drop_hold txdata got %h ack %b want 3c/0000", bus.Tx_Data, bus.Ack); end
        step();
        bus.Tx_Done = 1'b1;
        @(negedge Clk);
        n_checks++; if (bus.Ack !== 4'b0100 || bus.Err !== 1'b0) begin n_fail++; $display("FAIL drop_ack got %b/%b want 0100/0", bus.Ack, bus.Err); end
        step();
        bus.Tx_Done = 1'b0; bus.Req_Data = {dat[3], dat[2], dat[1], dat[0]};
        @(negedge Clk);
    endtask

    task automatic test_coincident();
        int n; bit ok; bit early;
        repeat (4) step();
        bus.Req = 4'b0001;
        wait_go(10, n, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL coin_go_timeout"); end
        early = 1'b0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            step();
            bus.Tx_Done = (i == TIMEOUT);
            @(negedge Clk);
            if (i < TIMEOUT && bus.Ack !== 4'b0000) early = 1'b1;
        end
        n_checks++; if (early) begin n_fail++; $display("FAIL coin_early_ack got early=1 want 0"); end
        n_checks++; if (bus.Ack !== 4'b0001) begin n_fail++; $display("FAIL coin_ack got %b want 0001", bus.Ack); end
        n_checks++; if (bus.Err !== 1'b0) begin n_fail++; $display("FAIL coin_err got %b want 0", bus.Err); end
        step();
        bus.Tx_Done = 1'b0; bus.Req = '0;
        @(negedge Clk);
    endtask

    task automatic test_reset_mid();
        int n; bit ok;
        repeat (6) step();
        bus.Req = 4'b1000;
        wait_go(10, n, ok);
        n_checks++; if (!ok || bus.Tx_Data !== dat[3]) begin n_fail++; $display("FAIL rmid_grant ok=%0b txdata got %h want %h", ok, bus.Tx_Data, dat[3]); end
        repeat (10) step();
        Reset = 1'b1; bus.Req = 4'b1001;
        @(negedge Clk);
        n_checks++; if (bus.Ack !== 4'b0000) begin n_fail++; $display("FAIL rmid_ack_in_reset got %b want 0000", bus.Ack); end
        step();
        Reset = 1'b0; bus.Tx_Done = 1'b1;
        @(negedge Clk);
        n_checks++; if (bus.Ack !== 4'b0000 || bus.Err !== 1'b0) begin n_fail++; $display("FAIL rmid_late_done got %b/%b want 0000/0", bus.Ack, bus.Err); end
        n_checks++; if (bus.Busy !== 1'b0 || bus.Tx_Send_Go !== 1'b0) begin n_fail++; $display("FAIL rmid_state busy=%b go=%b want 0/0", bus.Busy, bus.Tx_Send_Go); end
        n_checks++; if (bus.Tx_Data !== 8'h00) begin n_fail++; $display("FAIL rmid_txdata got %h want 00", bus.Tx_Data); end
        step();
        bus.Tx_Done = 1'b0;
        wait_go(10, n, ok);
        // Request latched in the previous (IDLE) cycle, so Go is one cycle away.
        n_checks++; if (!ok || n != 1) begin n_fail++; $display("FAIL rmid_regrant ok=%0b n=%0d want 1", ok, n); end
        n_checks++; if (bus.Tx_Data !== dat[0]) begin n_fail++; $display("FAIL rmid_first_grant txdata got %h want %h", bus.Tx_Data, dat[0]); end
        for (int i = 1; i <= 3; i++) begin
            step();
            bus.Tx_Done = (i == 3);
        end
        @(negedge Clk);
        n_checks++; if (bus.Ack !== 4'b0001) begin n_fail++; $display("FAIL rmid_ack got %b want 0001", bus.Ack); end
        step();
        bus.Tx_Done = 1'b0; bus.Req = '0;
        @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b1;
        bus.Req = '0;
        bus.Req_Data = '0;
        bus.Tx_Done = 1'b0;
        test_reset();
        test_single();
        test_reset();
        test_round_robin();
        test_timeout();
        test_stray_and_drop();
        test_coincident();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
